dtw_stream_feeder: RTL and testbench

Source side of the DTW core's sample handshake. Holds one reference sequence of SIZE samples in a register memory, buffers the incoming camera stream in a FIFO, and asserts `ready` to run the core. It answers each `ready_refer` / `ready_camera` request pulse with the next sample, then captures `score` when the core pulses `done`. It sits between the pose-extraction stream and the DTW core.

---
 rtl/dtw_stream_feeder_if.sv | 39 +++
 rtl/dtw_stream_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_dtw_stream_feeder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// dtw_stream_feeder_if
// Bundles the two streaming handshakes around the DTW feeder:
//   - camera stream : cam_valid / cam_data in, cam_ready out of the feeder
//   - core samples  : ready (run enable), ready_refer / ready_camera request
//                     pulses from the core, refer / camera samples back,
//                     score / done result strobe from the core
// Handshake semantics: a camera sample transfers on every rising edge where
// cam_valid and cam_ready are both high; cam_valid may not depend on
// cam_ready. The core pulses ready_refer / ready_camera for one cycle per
// sample wanted and reads refer / camera on the following cycle.
// Modports:
//   master : the feeder side (drives cam_ready, ready, refer, camera)
//   slave  : the upstream stream + DTW core side
// ---------------------------------------------------------------------------
interface dtw_stream_feeder_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  cam_valid;
    logic [DATA_WIDTH-1:0] cam_data;
    logic                  cam_ready;
    logic                  ready;
    logic                  ready_refer;
    logic [DATA_WIDTH-1:0] refer;
    logic                  ready_camera;
    logic [DATA_WIDTH-1:0] camera;
    logic [DATA_WIDTH-1:0] score;
    logic                  done;

    modport master (
        input  cam_valid, cam_data, ready_refer, ready_camera, score, done,
        output cam_ready, ready, refer, camera
    );

    modport slave (
        output cam_valid, cam_data, ready_refer, ready_camera, score, done,
        input  cam_ready, ready, refer, camera
    );
endinterface

// File: rtl/dtw_stream_feeder.sv
// ---------------------------------------------------------------------------
// dtw_stream_feeder
// Source side of the DTW core sample handshake. Keeps one reference sequence
// of SIZE samples in a register memory, buffers the camera stream in a FIFO,
// runs the core with `ready`, answers each sample request one cycle later and
// captures the core score on `done`.
//
// Optional feature macro: DTW_FEEDER_BEST_SCORE_EN
//   defined   : best_score tracks the minimum captured score
//   undefined : best_score is constant all-ones
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   ref_wr_en/addr/data reference memory write port (addr >= SIZE ignored)
//   start               begin one comparison (ignored while busy)
//   bus (master)        camera stream + core sample handshake
//   result/result_valid captured score and its one-cycle strobe
//   busy                high outside IDLE
//   err_underrun        sticky camera-request-on-empty flag
//   best_score          lowest captured score
//   dbg_state           FSM state (0 IDLE, 1 PRIME, 2 RUN)
// ---------------------------------------------------------------------------
module dtw_stream_feeder #(
    parameter int DATA_WIDTH = 10,
    parameter int SIZE       = 20,
    parameter int CAM_DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ref_wr_en,
    input  logic [$clog2(SIZE)-1:0]   ref_wr_addr,
    input  logic [DATA_WIDTH-1:0]     ref_wr_data,
    input  logic                      start,
    dtw_stream_feeder_if.master       bus,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      err_underrun,
    output logic [DATA_WIDTH-1:0]     best_score,
    output logic [1:0]                dbg_state
);
    localparam int AW = $clog2(SIZE);
    localparam int PW = $clog2(CAM_DEPTH);
    localparam logic [AW-1:0] REF_LAST = AW'(SIZE - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(CAM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Storage (no reset: reference survives rst_n, FIFO data is discarded
    // by clearing the pointers/count).
    logic [DATA_WIDTH-1:0] r_ref_mem [SIZE];
    logic [DATA_WIDTH-1:0] r_cam_mem [CAM_DEPTH];

    logic [AW-1:0]         r_ref_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_refer;
    logic [DATA_WIDTH-1:0] r_camera;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_result_valid;
    logic                  r_err_underrun;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start_acc;
    logic                  w_cam_req;
    logic                  w_underrun;
    logic                  w_ref_req;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_head      = r_cam_mem[r_rd_ptr];
    assign w_push      = bus.cam_valid & ~w_full;
    assign w_start_acc = (r_state == ST_IDLE) & start;
    assign w_cam_req   = (r_state == ST_RUN) & bus.ready_camera;
    assign w_underrun  = w_cam_req & w_empty;
    // Entering RUN preloads the first camera sample, hence the PRIME pop.
    assign w_pop       = ((r_state == ST_PRIME) | w_cam_req) & ~w_empty;
    assign w_ref_req   = ((r_state == ST_PRIME) | (r_state == ST_RUN)) & bus.ready_refer;
    assign w_capture   = (r_state == ST_RUN) & bus.done;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)    w_state_next = ST_PRIME;
            ST_PRIME: if (!w_empty) w_state_next = ST_RUN;
            ST_RUN:   if (bus.done) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready        <= 1'b0;
            r_ref_ptr      <= '0;
            r_refer        <= '0;
            r_camera       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_ready        <= (w_state_next == ST_RUN);
            r_result_valid <= w_capture;

            if (w_capture) begin
                r_result <= bus.score;
            end

            if (w_start_acc) begin
                r_ref_ptr      <= '0;
                r_err_underrun <= 1'b0;
            end else begin
                if (w_ref_req) begin
                    r_refer   <= r_ref_mem[r_ref_ptr];
                    r_ref_ptr <= (r_ref_ptr == REF_LAST) ? '0 : r_ref_ptr + 1'b1;
                end
                if (w_underrun) begin
                    r_err_underrun <= 1'b1;
                end
            end

            if (w_pop) begin
                r_camera <= w_head;
            end
        end
    end

    // ---------------- camera FIFO control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cam_mem[r_wr_ptr] <= bus.cam_data;
        end
    end

    // Reference memory: a same-address read in this cycle sees the old data
    // because the read above samples the array before this update lands.
    always_ff @(posedge clk) begin
        if (ref_wr_en && (int'(ref_wr_addr) < SIZE)) begin
            r_ref_mem[ref_wr_addr] <= ref_wr_data;
        end
    end

    // ---------------- best score ----------------
`ifdef DTW_FEEDER_BEST_SCORE_EN
    logic [DATA_WIDTH-1:0] r_best_score;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_score <= '1;
        end else if (w_capture && (bus.score < r_best_score)) begin
            r_best_score <= bus.score;
        end
    end

    assign best_score = r_best_score;
`else
    assign best_score = '1;
`endif

    // ---------------- outputs ----------------
    assign bus.cam_ready = ~w_full;
    assign bus.ready     = r_ready;
    assign bus.refer     = r_refer;
    assign bus.camera    = r_camera;
    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign busy          = (r_state != ST_IDLE);
    assign err_underrun  = r_err_underrun;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_dtw_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_dtw_stream_feeder
// Directed bench for dtw_stream_feeder: reference readout with wrap, camera
// ordering and result capture, underrun, FIFO full with concurrent push/pop,
// abort by reset, and best-score tracking (expectations follow the
// DTW_FEEDER_BEST_SCORE_EN macro).
// ---------------------------------------------------------------------------
module tb_dtw_stream_feeder;
    localparam int DW    = 10;
    localparam int SIZE  = 20;
    localparam int DEPTH = 32;
`ifdef DTW_FEEDER_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     ref_wr_en;
    logic [$clog2(SIZE)-1:0]  ref_wr_addr;
    logic [DW-1:0]            ref_wr_data;
    logic                     start;
    logic [DW-1:0]            result;
    logic                     result_valid;
    logic                     busy;
    logic                     err_underrun;
    logic [DW-1:0]            best_score;
    logic [1:0]               dbg_state;

    dtw_stream_feeder_if #(.DATA_WIDTH(DW)) bus ();

    dtw_stream_feeder #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE),
        .CAM_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_wr_en    (ref_wr_en),
        .ref_wr_addr  (ref_wr_addr),
        .ref_wr_data  (ref_wr_data),
        .start        (start),
        .bus          (bus),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err_underrun (err_underrun),
        .best_score   (best_score),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        bus.cam_valid = 1'b1;
        bus.cam_data  = v;
        tick();
        bus.cam_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run(input logic [DW-1:0] s, input int exp_best);
        bus.done  = 1'b1;
        bus.score = s;
        tick();
        bus.done  = 1'b0;
        check_eq("done_result", result, s);
        check_eq("done_rvalid", result_valid, 1);
        check_eq("done_ready_low", bus.ready, 0);
        check_eq("done_busy_low", busy, 0);
        check_eq("done_best", best_score, exp_best);
        tick();
        check_eq("rvalid_one_cycle", result_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_refer"}, bus.refer, 0);
        check_eq({tag, "_camera"}, bus.camera, 0);
        check_eq({tag, "_ready"}, bus.ready, 0);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_rvalid"}, result_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, err_underrun, 0);
        check_eq({tag, "_best"}, best_score, 1023);
        check_eq({tag, "_cam_ready"}, bus.cam_ready, 1);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n            = 1'b1;
        ref_wr_en        = 1'b0;
        ref_wr_addr      = '0;
        ref_wr_data      = '0;
        start            = 1'b0;
        bus.cam_valid    = 1'b0;
        bus.cam_data     = '0;
        bus.ready_refer  = 1'b0;
        bus.ready_camera = 1'b0;
        bus.score        = '0;
        bus.done         = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Run 1: reference readout with wrap, camera drain, score 50
        for (int k = 0; k < SIZE; k++) begin
            ref_wr_en   = 1'b1;
            ref_wr_addr = k[$clog2(SIZE)-1:0];
            ref_wr_data = DW'(k + 1);
            tick();
        end
        ref_wr_en = 1'b0;
        for (int i = 0; i < 20; i++) push(DW'(200 + i));
        pulse_start();
        check_eq("r1_busy", busy, 1);
        check_eq("r1_prime_ready", bus.ready, 0);
        tick();
        check_eq("r1_run_ready", bus.ready, 1);
        check_eq("r1_first_cam", bus.camera, 200);
        bus.ready_refer = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check_eq("r1_refer", bus.refer, (i % SIZE) + 1);
        end
        bus.ready_refer  = 1'b0;
        bus.ready_camera = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            check_eq("r1_cam_drain", bus.camera, 201 + i);
        end
        bus.ready_camera = 1'b0;
        check_eq("r1_no_underrun", err_underrun, 0);
        finish_run(DW'(50), BEST_EN ? 50 : 1023);

        // Run 2: camera ordering, score 20
        push(DW'(100));
        push(DW'(101));
        push(DW'(102));
        pulse_start();
        tick();
        check_eq("r2_enter_cam", bus.camera, 100);
        check_eq("r2_ready", bus.ready, 1);
        for (int i = 1; i < 3; i++) begin
            bus.ready_camera = 1'b1;
            tick();
            bus.ready_camera = 1'b0;
            check_eq("r2_cam", bus.camera, 100 + i);
        end
        finish_run(DW'(20), BEST_EN ? 20 : 1023);

        // Run 3: underrun, push into empty FIFO during underrun, score 35
        push(DW'(7));
        pulse_start();
        tick();
        check_eq("r3_enter_cam", bus.camera, 7);
        bus.ready_camera = 1'b1;
        tick();
        check_eq("r3_err", err_underrun, 1);
        check_eq("r3_cam_hold", bus.camera, 7);
        bus.cam_valid = 1'b1;
        bus.cam_data  = DW'(8);
        tick();
        bus.cam_valid = 1'b0;
        check_eq("r3_err_sticky", err_underrun, 1);
        check_eq("r3_cam_hold2", bus.camera, 7);
        tick();
        check_eq("r3_stored_push", bus.camera, 8);
        bus.ready_camera = 1'b0;
        finish_run(DW'(35), BEST_EN ? 20 : 1023);

        // Run 4: start clears flag, done ignored in PRIME, refer in PRIME
        pulse_start();
        check_eq("r4_err_clear", err_underrun, 0);
        check_eq("r4_state_prime", dbg_state, 1);
        bus.done  = 1'b1;
        bus.score = DW'(5);
        tick();
        bus.done = 1'b0;
        check_eq("r4_prime_done_rv", result_valid, 0);
        check_eq("r4_prime_done_res", result, 35);
        check_eq("r4_prime_busy", busy, 1);
        bus.ready_refer = 1'b1;
        tick();
        bus.ready_refer = 1'b0;
        check_eq("r4_prime_refer", bus.refer, 1);
        push(DW'(9));
        tick();
        check_eq("r4_cam", bus.camera, 9);
        finish_run(DW'(60), BEST_EN ? 20 : 1023);

        // Run 5: FIFO full, refused push, concurrent push/pop
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("r5_cam_ready_fill", bus.cam_ready, 1);
            push(DW'(300 + i));
        end
        check_eq("r5_full", bus.cam_ready, 0);
        bus.cam_valid = 1'b1;
        bus.cam_data  = DW'(999);
        tick();
        check_eq("r5_refused", bus.cam_ready, 0);
        pulse_start();
        check_eq("r5_prime_full", bus.cam_ready, 0);
        tick();
        check_eq("r5_enter_cam", bus.camera, 300);
        check_eq("r5_after_pop", bus.cam_ready, 1);
        bus.ready_camera = 1'b1;
        tick();
        bus.cam_valid = 1'b0;
        check_eq("r5_concurrent_cam", bus.camera, 301);
        check_eq("r5_concurrent_count", bus.cam_ready, 1);
        for (int i = 2; i < DEPTH; i++) begin
            tick();
            check_eq("r5_drain", bus.camera, 300 + i);
        end
        tick();
        check_eq("r5_last_push", bus.camera, 999);
        check_eq("r5_no_err", err_underrun, 0);
        tick();
        bus.ready_camera = 1'b0;
        check_eq("r5_err", err_underrun, 1);
        check_eq("r5_cam_hold", bus.camera, 999);

        // Abort by reset while in RUN
        bus.ready_refer = 1'b1;
        tick();
        bus.ready_refer = 1'b0;
        check_eq("r6_refer_pre", bus.refer, 1);
        check_eq("r6_in_run", bus.ready, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("abort");
        tick();
        tick();
        rst_n = 1'b1;
        push(DW'(5));
        pulse_start();
        tick();
        check_eq("r6_cam", bus.camera, 5);
        bus.ready_refer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("r6_mem_kept", bus.refer, i + 1);
        end
        bus.ready_refer  = 1'b0;
        bus.ready_camera = 1'b1;
        tick();
        bus.ready_camera = 1'b0;
        check_eq("r6_fifo_discarded", err_underrun, 1);
        check_eq("r6_cam_hold", bus.camera, 5);
        finish_run(DW'(11), BEST_EN ? 11 : 1023);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
